bcd_conv_param: RTL and testbench

Parametrised, handshaked binary-to-BCD converter for the display and measurement path. Converts one BIN_W-bit word per request into DIGITS packed BCD digits using a single-phase double-dabble iteration: add-3 correction and shift happen in the same cycle, one input bit per cycle. Adds features the fixed 8-digit converter lacks: a two's-complement signed mode, an overflow flag, a leading-zero blank mask, and valid/ready flow control. It sits between the measurement counters and the seven-segment/UI formatting logic.

---
 rtl/bcd_conv_param_if.sv | 26 ++
 rtl/bcd_conv_param.sv | 121 ++++++++++++
 tb/tb_bcd_conv_param.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_conv_param_if.sv
// Handshake and result bundle for the binary-to-BCD converter.
// The slave side is the converter; the master side is whoever feeds it and consumes results.
interface bcd_conv_param_if #(
  parameter int unsigned BIN_W  = 32,
  parameter int unsigned DIGITS = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      data_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic                  ovf;
  logic [DIGITS-1:0]     blank;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, bcd, neg, ovf, blank
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, bcd, neg, ovf, blank
  );
endinterface

// File: rtl/bcd_conv_param.sv
// Handshaked binary-to-BCD converter: single-phase double-dabble, one input bit per cycle.
// Optional two's-complement input (sign + magnitude), sticky overflow and leading-zero blank mask.
module bcd_conv_param #(
  parameter int unsigned BIN_W  = 32,
  parameter int unsigned DIGITS = 10,
  parameter bit          SIGNED = 1'b0
) (
  input logic             sys_clk,
  input logic             sys_rst,
  bcd_conv_param_if.slave bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W);
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e             state_q;
  logic [BIN_W-1:0]   bin_q;
  logic [BCD_W-1:0]   work_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_acc_q;
  logic               sign_q;
  logic [BCD_W-1:0]   bcd_q;
  logic               neg_q;
  logic               ovf_q;
  logic [DIGITS-1:0]  blank_q;

  logic [BIN_W-1:0]   mag_in;
  logic               sign_in;
  logic [BCD_W-1:0]   corrected;
  logic [BCD_W-1:0]   shifted;
  logic               top_bit;
  logic [DIGITS-1:0]  blank_next;
  logic               zero_run;

  // Negative inputs load their magnitude; the most negative value maps to 2^(BIN_W-1) exactly.
  assign sign_in = SIGNED & bus.data_in[BIN_W-1];
  assign mag_in  = sign_in ? (~bus.data_in + BIN_W'(1)) : bus.data_in;

  // Add-3 correction on every digit above 4 ahead of the shift.
  always_comb begin
    corrected = work_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (work_q[4*i +: 4] > 4'd4) begin
        corrected[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign shifted = {corrected[BCD_W-2:0], bin_q[BIN_W-1]};
  // A one leaving the top digit means the value reached 10^DIGITS.
  assign top_bit = corrected[BCD_W-1];

  // Blank mask from the final digits: a bit is set while all digits at and above it are zero.
  always_comb begin
    zero_run   = 1'b1;
    blank_next = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run      = zero_run & (shifted[4*i +: 4] == 4'd0);
      blank_next[i] = zero_run;
    end
  end

  // Control FSM, iteration datapath and registered result.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      sign_q    <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      blank_q   <= BLANK_RST;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            bin_q     <= mag_in;
            sign_q    <= sign_in;
            work_q    <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StConv;
          end
        end
        StConv: begin
          bin_q     <= {bin_q[BIN_W-2:0], 1'b0};
          work_q    <= shifted;
          ovf_acc_q <= ovf_acc_q | top_bit;
          cnt_q     <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BIN_W - 1)) begin
            bcd_q   <= shifted;
            neg_q   <= sign_q;
            ovf_q   <= ovf_acc_q | top_bit;
            blank_q <= blank_next;
            state_q <= StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.bcd       = bcd_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;
  assign bus.blank     = blank_q;

endmodule

// File: tb/tb_bcd_conv_param.sv
// Self-checking bench for bcd_conv_param: three configurations, directed table, random vs. model,
// backpressure and mid-conversion reset sequences.
module tb_bcd_conv_param;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bcd_conv_param_if #(.BIN_W(32), .DIGITS(10)) if_a ();
  bcd_conv_param_if #(.BIN_W(16), .DIGITS(5))  if_b ();
  bcd_conv_param_if #(.BIN_W(16), .DIGITS(4))  if_c ();

  bcd_conv_param #(.BIN_W(32), .DIGITS(10), .SIGNED(1'b0)) u_dut_a (
    .sys_clk(clk), .sys_rst(rst), .bus(if_a.slave)
  );
  bcd_conv_param #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b1)) u_dut_b (
    .sys_clk(clk), .sys_rst(rst), .bus(if_b.slave)
  );
  bcd_conv_param #(.BIN_W(16), .DIGITS(4), .SIGNED(1'b0)) u_dut_c (
    .sys_clk(clk), .sys_rst(rst), .bus(if_c.slave)
  );

  typedef struct {
    int          k;
    logic [63:0] din;
    logic [79:0] bcd;
    logic        neg;
    logic        ovf;
    logic [19:0] blank;
  } vec_t;

  vec_t vecs[8];

  function automatic int bw(int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic int dg(int k);
    return (k == 0) ? 10 : ((k == 1) ? 5 : 4);
  endfunction

  // Reference: plain arithmetic on the magnitude, decimal digits by division.
  function automatic void ref_model(input int k, input logic [63:0] din, output logic [79:0] b,
                                    output logic n, output logic o, output logic [19:0] bl);
    logic [63:0] mag, p, m, pw;
    int w, d;
    w   = bw(k);
    d   = dg(k);
    mag = din & ((64'd1 << w) - 64'd1);
    n   = 1'b0;
    if (k == 1 && mag[w-1]) begin
      n   = 1'b1;
      mag = (64'd1 << w) - mag;
    end
    p = 64'd1;
    for (int i = 0; i < d; i++) p = p * 64'd10;
    o  = (mag >= p);
    m  = mag % p;
    b  = '0;
    bl = '0;
    pw = 64'd1;
    for (int i = 0; i < d; i++) begin
      if (i > 0 && (m / pw) == 64'd0) bl[i] = 1'b1;
      b[4*i +: 4] = 4'((m / pw) % 64'd10);
      pw = pw * 64'd10;
    end
  endfunction

  task automatic set_in(input int k, input logic v, input logic [63:0] d, input logic r);
    case (k)
      0: begin if_a.in_valid = v; if_a.data_in = d[31:0]; if_a.out_ready = r; end
      1: begin if_b.in_valid = v; if_b.data_in = d[15:0]; if_b.out_ready = r; end
      default: begin if_c.in_valid = v; if_c.data_in = d[15:0]; if_c.out_ready = r; end
    endcase
  endtask

  task automatic get_out(input int k, output logic rdy, output logic vld, output logic [79:0] b,
                         output logic n, output logic o, output logic [19:0] bl);
    case (k)
      0: begin
        rdy = if_a.in_ready; vld = if_a.out_valid; b = 80'(if_a.bcd);
        n = if_a.neg; o = if_a.ovf; bl = 20'(if_a.blank);
      end
      1: begin
        rdy = if_b.in_ready; vld = if_b.out_valid; b = 80'(if_b.bcd);
        n = if_b.neg; o = if_b.ovf; bl = 20'(if_b.blank);
      end
      default: begin
        rdy = if_c.in_ready; vld = if_c.out_valid; b = 80'(if_c.bcd);
        n = if_c.neg; o = if_c.ovf; bl = 20'(if_c.blank);
      end
    endcase
  endtask

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present a request and hold it until accepted; returns #1 after the accept edge.
  task automatic start_conv(input int k, input logic [63:0] d);
    logic rdy, vld, n, o;
    logic [79:0] b;
    logic [19:0] bl;
    int tries;
    tries = 0;
    @(negedge clk);
    set_in(k, 1'b1, d, 1'b0);
    get_out(k, rdy, vld, b, n, o, bl);
    while (!rdy && tries < 100) begin
      @(negedge clk);
      get_out(k, rdy, vld, b, n, o, bl);
      tries++;
    end
    if (!rdy) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected in_ready=1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    // Data changes after the accept edge must not disturb the conversion.
    set_in(k, 1'b0, {$urandom, $urandom}, 1'b0);
  endtask

  task automatic wait_valid(input int k);
    logic rdy, vld, n, o;
    logic [79:0] b;
    logic [19:0] bl;
    int lat;
    lat = 0;
    vld = 1'b0;
    while (!vld && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      get_out(k, rdy, vld, b, n, o, bl);
    end
    chk("latency", 80'(lat), 80'(bw(k)));
  endtask

  task automatic check_exp(input int k, input string tag, input logic [79:0] eb, input logic en,
                           input logic eo, input logic [19:0] ebl);
    logic rdy, vld, n, o;
    logic [79:0] b;
    logic [19:0] bl;
    get_out(k, rdy, vld, b, n, o, bl);
    chk({tag, ".bcd"}, b, eb);
    chk({tag, ".neg"}, 80'(n), 80'(en));
    chk({tag, ".ovf"}, 80'(o), 80'(eo));
    chk({tag, ".blank"}, 80'(bl), 80'(ebl));
  endtask

  task automatic check_ref(input int k, input string tag, input logic [63:0] din);
    logic [79:0] eb;
    logic en, eo;
    logic [19:0] ebl;
    ref_model(k, din, eb, en, eo, ebl);
    check_exp(k, tag, eb, en, eo, ebl);
  endtask

  task automatic release_out(input int k);
    @(negedge clk);
    set_in(k, 1'b0, '0, 1'b1);
    @(posedge clk);
    #1;
    set_in(k, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic rdy, vld, n, o, rdy2, vld2, n2, o2;
    logic [79:0] b, b2;
    logic [19:0] bl, bl2;
    logic [63:0] d;
    int vcount;

    vecs[0] = '{0, 64'd99999999,    80'h0099999999, 1'b0, 1'b0, 20'b1100000000};
    vecs[1] = '{0, 64'hFFFFFFFF,    80'h4294967295, 1'b0, 1'b0, 20'b0};
    vecs[2] = '{0, 64'd0,           80'h0,          1'b0, 1'b0, 20'b1111111110};
    vecs[3] = '{1, 64'h8000,        80'h32768,      1'b1, 1'b0, 20'b0};
    vecs[4] = '{1, 64'hFFFF,        80'h00001,      1'b1, 1'b0, 20'b11110};
    vecs[5] = '{1, 64'h7FFF,        80'h32767,      1'b0, 1'b0, 20'b0};
    vecs[6] = '{2, 64'd12345,       80'h2345,       1'b0, 1'b1, 20'b0};
    vecs[7] = '{2, 64'd9999,        80'h9999,       1'b0, 1'b0, 20'b0};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) set_in(k, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    get_out(0, rdy, vld, b, n, o, bl);
    chk("rst.in_ready", 80'(rdy), 80'd1);
    chk("rst.out_valid", 80'(vld), 80'd0);
    check_exp(0, "rst", 80'h0, 1'b0, 1'b0, 20'b1111111110);
    check_exp(1, "rst_b", 80'h0, 1'b0, 1'b0, 20'b11110);

    // Directed table.
    foreach (vecs[i]) begin
      start_conv(vecs[i].k, vecs[i].din);
      wait_valid(vecs[i].k);
      check_exp(vecs[i].k, $sformatf("vec%0d", i), vecs[i].bcd, vecs[i].neg, vecs[i].ovf,
                vecs[i].blank);
      release_out(vecs[i].k);
    end

    // Random stimulus against the model.
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 12; j++) begin
        d = {$urandom, $urandom};
        if (j % 4 == 1) d = 64'($urandom_range(0, 999));
        start_conv(k, d);
        wait_valid(k);
        check_ref(k, $sformatf("rnd%0d_%0d", k, j), d);
        release_out(k);
      end
    end

    // Backpressure: outputs frozen while a new request waits on in_valid.
    start_conv(0, 64'd1234);
    wait_valid(0);
    check_ref(0, "bp_first", 64'd1234);
    get_out(0, rdy, vld, b, n, o, bl);
    @(negedge clk);
    set_in(0, 1'b1, 64'd777, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      get_out(0, rdy2, vld2, b2, n2, o2, bl2);
      chk("bp.bcd", b2, b);
      chk("bp.blank", 80'(bl2), 80'(bl));
      chk("bp.flags", 80'({n2, o2}), 80'({n, o}));
      chk("bp.in_ready", 80'(rdy2), 80'd0);
      chk("bp.out_valid", 80'(vld2), 80'd1);
    end
    @(negedge clk);
    set_in(0, 1'b1, 64'd777, 1'b1);
    @(posedge clk);
    #1;
    get_out(0, rdy, vld, b, n, o, bl);
    chk("bp_rel.in_ready", 80'(rdy), 80'd1);
    chk("bp_rel.out_valid", 80'(vld), 80'd0);
    @(negedge clk);
    set_in(0, 1'b1, 64'd777, 1'b0);
    @(posedge clk);
    #1;
    get_out(0, rdy, vld, b, n, o, bl);
    chk("bp_acc.in_ready", 80'(rdy), 80'd0);
    set_in(0, 1'b0, {$urandom, $urandom}, 1'b0);
    wait_valid(0);
    check_ref(0, "bp_second", 64'd777);
    release_out(0);

    // Reset on the edge of iteration 10 aborts the conversion.
    start_conv(0, 64'd55555);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    get_out(0, rdy, vld, b, n, o, bl);
    chk("abort.in_ready", 80'(rdy), 80'd1);
    chk("abort.out_valid", 80'(vld), 80'd0);
    check_exp(0, "abort", 80'h0, 1'b0, 1'b0, 20'b1111111110);
    @(negedge clk);
    rst = 1'b0;
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      get_out(0, rdy, vld, b, n, o, bl);
      if (vld) vcount++;
    end
    chk("abort.no_valid", 80'(vcount), 80'd0);
    start_conv(0, 64'd4321);
    wait_valid(0);
    check_ref(0, "after_abort", 64'd4321);
    release_out(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2000000");
    $fatal(1);
  end

endmodule
